tone_mixer: RTL and testbench
=============================

Name: tone_mixer

Overview:
Multi-channel tone source that feeds the i2s_tx sample interface. It replaces the single fixed-tuning DDS and constant divide-by-8 scaling with NCH runtime-configurable oscillators. Each oscillator has its own tuning word, waveform, gain shift and stereo pan. On each frame request the block time-multiplexes one shared datapath across all channels, sums them into stereo L/R samples, and presents the result with a one-cycle valid strobe.

Parameters:
DW, 24, output sample width (signed)
NCH, 4, number of oscillator channels (>=2)
PW, 24, phase accumulator width (PW >= DW)
TW, 16, tuning word width (TW <= PW)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_req  in  1  one-cycle pulse requesting the next stereo frame (lrclk falling edge)
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NCH)  channel index for write
cfg_en  in  1  channel enable
cfg_wave  in  2  waveform select (0 saw, 1 square, 2 triangle, 3 noise)
cfg_gain  in  4  arithmetic right-shift applied to waveform
cfg_pan  in  2  bit1 = route to L, bit0 = route to R
cfg_tuning  in  TW  phase increment per frame
l_sample  out  DW  left output, signed
r_sample  out  DW  right output, signed
valid  out  1  one-cycle strobe; l/r_sample updated this cycle
busy  out  1  high while a frame is being computed
overrun  out  1  sticky: frame_req arrived while busy

Behaviour:
- Reset (async assert, sync deassert internally): l/r_sample=0, valid=0, busy=0, overrun=0, FSM=IDLE.
- Reset also clears all phases to 0, all channel config to 0 (disabled), and sets the LFSR to 24'h000001.
- FSM has three states: IDLE, ACCUM, OUT.
- IDLE: on frame_req, clear L/R accumulators, set ch_idx=0, go to ACCUM. busy=1 from the next cycle.
- ACCUM: processes channel ch_idx each cycle. After ch_idx==NCH-1, go to OUT.
- OUT: drive l/r_sample, valid=1 for one cycle, busy=0, return to IDLE.
- Latency: frame_req at cycle 0 -> valid at cycle NCH+1. Minimum frame period is NCH+2 cycles.
- Per-channel step, using the phase value before increment. Let p = phase[PW-1 -: DW] (unsigned).
  - saw: p reinterpreted as signed.
  - square: p[DW-1] ? -(2^(DW-1)-1) : +(2^(DW-1)-1).
  - triangle: f = p[DW-1] ? ~p : p, truncated to DW-1 bits; output = (f<<1) - 2^(DW-1).
  - noise: current LFSR state reinterpreted as signed.
- The LFSR is a 24-bit Galois LFSR with taps x^24+x^23+x^22+x^17+1. It advances once per processed channel whose wave=3 and en=1. Its top DW bits are used when DW<24; it is zero-extended on the LSB side when DW>24.
- Scaled value: wave >>> gain (sign-preserving).
- Routing: add the scaled value to the L accumulator if pan[1], to the R accumulator if pan[0].
- Accumulators are DW+$clog2(NCH) bits wide.
- After the sample is taken, phase += zero-extended tuning, modulo 2^PW (wraps silently).
- Disabled channel: contributes 0, phase holds, LFSR does not advance.
- Config write: registers commit at the clock edge, in any state.
  - A write to the channel processed in the same cycle takes effect next frame; the current step uses the old values.
  - A write with cfg_en=0 also clears that channel's phase to 0.
  - cfg_ch >= NCH: write ignored.
- frame_req while busy (ACCUM or OUT): ignored, overrun<=1. overrun clears only on reset.
- frame_req coincident with the OUT cycle is also treated as an overrun. The next frame_req must arrive in IDLE.
- Reset mid-frame: computation aborts, valid never asserts for that frame, all state returns to reset values.

Optional Feature:
MIX_SAT_EN
- Defined: l/r_sample = accumulator saturated to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: l/r_sample = accumulator >>> $clog2(NCH), truncated to DW bits. This averages the channels and never clips, at the cost of headroom.

Decomposition:
- tone_mixer_pkg holds:
  - wave_t enum (WAVE_SAW=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_NOISE=3)
  - state_t enum (S_IDLE, S_ACCUM, S_OUT)
  - LFSR_TAPS = 24'hE10000 and LFSR_SEED = 24'h000001
  - saturate function
- One sub-module, tone_wave_gen: combinational; inputs phase top DW bits, wave, LFSR state; output signed DW-bit sample. Instantiated once in the shared datapath.

Test Plan:
- Reset: hold rst_n=0 and toggle frame_req -> valid, busy, overrun, l/r_sample all 0. After release, a frame_req with all channels disabled gives valid at +5 cycles (NCH=4) with l=r=0.
- Saw, ch0: tuning=16'h1000, gain=0, pan=2'b11, other channels disabled. Three frames -> l=r=0, then 4096, then 8192. valid exactly NCH+1 cycles after each frame_req.
- Square, ch0+ch1: gain=0, pan=11, phase 0.
  - MIX_SAT_EN defined -> l=r=8388607 (saturated from 16777214).
  - MIX_SAT_EN undefined -> l=r=4194303.
- Pan/gain, ch2 only: square, gain=1, pan=2'b10 -> l=4194303 (MIX_SAT_EN defined), r=0.
- Overrun: second frame_req 2 cycles after the first -> exactly one valid, overrun=1 and stays 1 through later frames until rst_n pulses.
- Reset mid-ACCUM: assert rst_n=0 at cycle 2 after frame_req -> busy drops immediately, no valid. After release, the ch0 saw from the second scenario restarts at phase 0 (output 0).

Source files
------------

// File: rtl/tone_mixer_pkg.sv
// ----------------------------------------------------------------------------
// tone_mixer_pkg : shared types, LFSR constants and helpers for tone_mixer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tone_mixer_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Galois form of x^24+x^23+x^22+x^17+1, shifting right
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;
  localparam logic [23:0] LFSR_SEED = 24'h000001;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 24'h000000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_wave_gen.sv
// ----------------------------------------------------------------------------
// tone_wave_gen : combinational saw/square/triangle/noise shaper for one channel
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tone_wave_gen
  import tone_mixer_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic [DW-1:0]        phase_top,
  input  logic [1:0]           wave,
  input  logic [23:0]          lfsr,
  output logic signed [DW-1:0] sample
);

  localparam logic [DW-1:0] HALF   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] SQ_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SQ_NEG = {1'b1, {(DW-2){1'b0}}, 1'b1};

  logic [DW-1:0] noise_val;
  logic [DW-2:0] fold_val;
  logic [DW-1:0] tri_val;

  // LFSR is 24 bits wide; align its MSB with the sample MSB
  generate
    if (DW < 24) begin : g_noise_trunc
      assign noise_val = lfsr[23 -: DW];
    end else if (DW == 24) begin : g_noise_direct
      assign noise_val = lfsr;
    end else begin : g_noise_extend
      assign noise_val = {lfsr, {(DW-24){1'b0}}};
    end
  endgenerate

  always_comb begin
    fold_val = phase_top[DW-1] ? ~phase_top[DW-2:0] : phase_top[DW-2:0];
    tri_val  = {fold_val, 1'b0} - HALF;
  end

  always_comb begin
    sample = $signed(phase_top);
    case (wave_t'(wave))
      WAVE_SAW:    sample = $signed(phase_top);
      WAVE_SQUARE: sample = phase_top[DW-1] ? $signed(SQ_NEG) : $signed(SQ_POS);
      WAVE_TRI:    sample = $signed(tri_val);
      WAVE_NOISE:  sample = $signed(noise_val);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tone_mixer.sv
// ----------------------------------------------------------------------------
// tone_mixer : NCH time-multiplexed oscillators summed to stereo; MIX_SAT_EN selects saturation
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tone_mixer
  import tone_mixer_pkg::*;
#(
  parameter int DW  = 24,
  parameter int NCH = 4,
  parameter int PW  = 24,
  parameter int TW  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_req,
  input  logic                      cfg_we,
  input  logic [$clog2(NCH)-1:0]    cfg_ch,
  input  logic                      cfg_en,
  input  logic [1:0]                cfg_wave,
  input  logic [3:0]                cfg_gain,
  input  logic [1:0]                cfg_pan,
  input  logic [TW-1:0]             cfg_tuning,
  output logic signed [DW-1:0]      l_sample,
  output logic signed [DW-1:0]      r_sample,
  output logic                      valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CW = $clog2(NCH);
  localparam int AW = DW + CW;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_idx_q, ch_idx_d;
  logic signed [AW-1:0]  acc_l_q, acc_l_d;
  logic signed [AW-1:0]  acc_r_q, acc_r_d;
  logic [PW-1:0]         phase_q [NCH];
  logic [PW-1:0]         phase_d [NCH];
  logic [NCH-1:0]        en_q, en_d;
  logic [1:0]            wave_q [NCH];
  logic [1:0]            wave_d [NCH];
  logic [3:0]            gain_q [NCH];
  logic [3:0]            gain_d [NCH];
  logic [1:0]            pan_q [NCH];
  logic [1:0]            pan_d [NCH];
  logic [TW-1:0]         tuning_q [NCH];
  logic [TW-1:0]         tuning_d [NCH];
  logic [23:0]           lfsr_q, lfsr_d;
  logic signed [DW-1:0]  l_sample_q, l_sample_d;
  logic signed [DW-1:0]  r_sample_q, r_sample_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic [DW-1:0]         phase_top;
  logic signed [DW-1:0]  wave_val;
  logic signed [DW-1:0]  scaled_val;
  logic signed [AW-1:0]  scaled_ext;
  logic signed [DW-1:0]  mix_l, mix_r;

  // Reset asserts asynchronously but releases only after two clean edges
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  assign phase_top = phase_q[ch_idx_q][PW-1 -: DW];

  tone_wave_gen #(
    .DW (DW)
  ) u_wave_gen (
    .phase_top (phase_top),
    .wave      (wave_q[ch_idx_q]),
    .lfsr      (lfsr_q),
    .sample    (wave_val)
  );

  assign scaled_val = wave_val >>> gain_q[ch_idx_q];
  assign scaled_ext = {{CW{scaled_val[DW-1]}}, scaled_val};

`ifdef MIX_SAT_EN
  assign mix_l = DW'(saturate(64'(acc_l_d), DW));
  assign mix_r = DW'(saturate(64'(acc_r_d), DW));
`else
  assign mix_l = DW'(acc_l_d >>> CW);
  assign mix_r = DW'(acc_r_d >>> CW);
`endif

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    phase_d    = phase_q;
    en_d       = en_q;
    wave_d     = wave_q;
    gain_d     = gain_q;
    pan_d      = pan_q;
    tuning_d   = tuning_q;
    lfsr_d     = lfsr_q;
    l_sample_d = l_sample_q;
    r_sample_d = r_sample_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          acc_l_d  = '0;
          acc_r_d  = '0;
          ch_idx_d = '0;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (frame_req) overrun_d = 1'b1;
        if (en_q[ch_idx_q]) begin
          if (pan_q[ch_idx_q][1]) acc_l_d = acc_l_q + scaled_ext;
          if (pan_q[ch_idx_q][0]) acc_r_d = acc_r_q + scaled_ext;
          phase_d[ch_idx_q] = phase_q[ch_idx_q] + PW'(tuning_q[ch_idx_q]);
          if (wave_q[ch_idx_q] == WAVE_NOISE) lfsr_d = lfsr_step(lfsr_q);
        end
        if (ch_idx_q == CW'(NCH - 1)) begin
          l_sample_d = mix_l;
          r_sample_d = mix_r;
          valid_d    = 1'b1;
          state_d    = S_OUT;
        end else begin
          ch_idx_d = ch_idx_q + CW'(1);
        end
      end
      S_OUT: begin
        if (frame_req) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Config lands after the datapath so a disable-clear beats the phase step
    if (cfg_we && (int'(cfg_ch) < NCH)) begin
      en_d[cfg_ch]     = cfg_en;
      wave_d[cfg_ch]   = cfg_wave;
      gain_d[cfg_ch]   = cfg_gain;
      pan_d[cfg_ch]    = cfg_pan;
      tuning_d[cfg_ch] = cfg_tuning;
      if (!cfg_en) phase_d[cfg_ch] = '0;
    end

    busy_d = (state_d == S_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= S_IDLE;
      ch_idx_q   <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      en_q       <= '0;
      lfsr_q     <= LFSR_SEED;
      l_sample_q <= '0;
      r_sample_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        phase_q[i]  <= '0;
        wave_q[i]   <= '0;
        gain_q[i]   <= '0;
        pan_q[i]    <= '0;
        tuning_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      en_q       <= en_d;
      lfsr_q     <= lfsr_d;
      l_sample_q <= l_sample_d;
      r_sample_q <= r_sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      phase_q    <= phase_d;
      wave_q     <= wave_d;
      gain_q     <= gain_d;
      pan_q      <= pan_d;
      tuning_q   <= tuning_d;
    end
  end

  assign l_sample = l_sample_q;
  assign r_sample = r_sample_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_mixer.sv
// ----------------------------------------------------------------------------
// tb_tone_mixer : directed stimulus with a frame-level reference model for tone_mixer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tone_mixer;

  localparam int     DW   = 24;
  localparam int     NCH  = 4;
  localparam int     PW   = 24;
  localparam int     TW   = 16;
  localparam int     CW   = $clog2(NCH);
  localparam longint HALF = 64'sd1 << (DW - 1);

`ifdef MIX_SAT_EN
  localparam longint SAW1 = 4096;
  localparam longint SAW2 = 8192;
  localparam longint SQ2  = 8388607;
  localparam longint SQG1 = 4194303;
`else
  localparam longint SAW1 = 1024;
  localparam longint SAW2 = 2048;
  localparam longint SQ2  = 4194303;
  localparam longint SQG1 = 1048575;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  frame_req = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [CW-1:0]         cfg_ch = '0;
  logic                  cfg_en = 1'b0;
  logic [1:0]            cfg_wave = '0;
  logic [3:0]            cfg_gain = '0;
  logic [1:0]            cfg_pan = '0;
  logic [TW-1:0]         cfg_tuning = '0;
  logic signed [DW-1:0]  l_sample;
  logic signed [DW-1:0]  r_sample;
  logic                  valid;
  logic                  busy;
  logic                  overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_mixer #(.DW(DW), .NCH(NCH), .PW(PW), .TW(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_wave   (cfg_wave),
    .cfg_gain   (cfg_gain),
    .cfg_pan    (cfg_pan),
    .cfg_tuning (cfg_tuning),
    .l_sample   (l_sample),
    .r_sample   (r_sample),
    .valid      (valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- reference model: whole frame evaluated at acceptance ----
  longint     m_phase [NCH];
  bit         m_en    [NCH];
  int         m_wave  [NCH];
  int         m_gain  [NCH];
  int         m_pan   [NCH];
  longint     m_tun   [NCH];
  logic [23:0] m_lfsr;
  longint     m_k, m_e, m_pl, m_pr, m_ol, m_or;
  bit         m_ovr;

  function automatic logic [23:0] lfsr_next(input logic [23:0] s);
    return (s >> 1) ^ (s[0] ? 24'hE10000 : 24'h000000);
  endfunction

  task automatic model_frame();
    longint al, ar, p, w, f;
    al = 0;
    ar = 0;
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c]) begin
        p = (m_phase[c] >> (PW - DW)) & ((64'sd1 << DW) - 1);
        case (m_wave[c])
          0: w = (p >= HALF) ? p - 2 * HALF : p;
          1: w = (p >= HALF) ? -(HALF - 1) : (HALF - 1);
          2: begin
            f = (p >= HALF) ? (~p & (HALF - 1)) : (p & (HALF - 1));
            w = 2 * f - HALF;
          end
          default: begin
            w = longint'(m_lfsr);
            if (w >= HALF) w = w - 2 * HALF;
            m_lfsr = lfsr_next(m_lfsr);
          end
        endcase
        w = w >>> m_gain[c];
        if (m_pan[c] >= 2) al += w;
        if (m_pan[c] % 2 == 1) ar += w;
        m_phase[c] = (m_phase[c] + m_tun[c]) % (64'sd1 << PW);
      end
    end
`ifdef MIX_SAT_EN
    m_pl = (al > HALF - 1) ? HALF - 1 : (al < -HALF) ? -HALF : al;
    m_pr = (ar > HALF - 1) ? HALF - 1 : (ar < -HALF) ? -HALF : ar;
`else
    m_pl = al >>> CW;
    m_pr = ar >>> CW;
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_phase[c] = 0; m_en[c] = 0; m_wave[c] = 0;
        m_gain[c] = 0;  m_pan[c] = 0; m_tun[c] = 0;
      end
      m_lfsr = 24'h000001;
      m_k = 0; m_e = -100; m_pl = 0; m_pr = 0; m_ol = 0; m_or = 0;
      m_ovr = 0;
    end else begin
      m_k++;
      if (m_k == m_e + NCH) begin
        m_ol = m_pl;
        m_or = m_pr;
      end
      if (frame_req) begin
        if (m_k >= m_e + NCH + 2) begin
          m_e = m_k;
          model_frame();
        end else begin
          m_ovr = 1;
        end
      end
      if (cfg_we) begin
        m_en[cfg_ch]   = cfg_en;
        m_wave[cfg_ch] = int'(cfg_wave);
        m_gain[cfg_ch] = int'(cfg_gain);
        m_pan[cfg_ch]  = int'(cfg_pan);
        m_tun[cfg_ch]  = longint'(cfg_tuning);
        if (!cfg_en) m_phase[cfg_ch] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid",   valid,    (m_k == m_e + NCH));
    chk("cyc_busy",    busy,     (m_k >= m_e && m_k <= m_e + NCH - 1));
    chk("cyc_overrun", overrun,  m_ovr);
    chk("cyc_l",       l_sample, m_ol);
    chk("cyc_r",       r_sample, m_or);
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int en, input int wave, input int gain,
                     input int pan, input int tun);
    cfg_we     = 1'b1;
    cfg_ch     = CW'(ch);
    cfg_en     = (en != 0);
    cfg_wave   = 2'(wave);
    cfg_gain   = 4'(gain);
    cfg_pan    = 2'(pan);
    cfg_tuning = TW'(tun);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic frame(input string nm, input longint el, input longint er,
                       input bit lit);
    int n;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n + 1, NCH + 1);
    if (lit) begin
      chk({nm, "_l"}, l_sample, el);
      chk({nm, "_r"}, r_sample, er);
    end
    tick();
  endtask

  task automatic release_reset();
    frame_req = 1'b0;
    rst_n     = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int vcount;
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    #2;
    for (int i = 0; i < 4; i++) begin
      frame_req = ~frame_req;
      tick();
    end
    chk("rst_valid",   valid,    0);
    chk("rst_busy",    busy,     0);
    chk("rst_overrun", overrun,  0);
    chk("rst_l",       l_sample, 0);
    chk("rst_r",       r_sample, 0);
    release_reset();

    frame("idle", 0, 0, 1);

    cfg(0, 1, 0, 0, 3, 'h1000);
    frame("saw0", 0, 0, 1);
    frame("saw1", SAW1, SAW1, 1);
    frame("saw2", SAW2, SAW2, 1);

    cfg(0, 0, 0, 0, 0, 0);
    cfg(0, 1, 1, 0, 3, 0);
    cfg(1, 1, 1, 0, 3, 0);
    frame("square", SQ2, SQ2, 1);

    cfg(0, 0, 0, 0, 0, 0);
    cfg(1, 0, 0, 0, 0, 0);
    cfg(2, 1, 1, 1, 2, 0);
    frame("pan_gain", SQG1, 0, 1);

    cfg(2, 0, 0, 0, 0, 0);
    cfg(1, 1, 2, 2, 3, 'hFFFF);
    cfg(3, 1, 3, 0, 1, 0);
    cfg(0, 1, 0, 1, 2, 'h7777);
    for (int i = 0; i < 4; i++) frame("mix", 0, 0, 0);

    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      vcount += int'(valid);
      tick();
    end
    chk("ovr_valid_count", vcount, 1);
    chk("ovr_set", overrun, 1);
    frame("post_ovr", 0, 0, 0);
    chk("ovr_sticky", overrun, 1);

    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    busy,    0);
    chk("midrst_valid",   valid,   0);
    chk("midrst_overrun", overrun, 0);
    vcount = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vcount += int'(valid);
    end
    release_reset();
    for (int i = 0; i < 4; i++) begin
      vcount += int'(valid);
      tick();
    end
    chk("midrst_no_valid", vcount, 0);
    cfg(0, 1, 0, 0, 3, 'h1000);
    frame("restart", 0, 0, 1);
    frame("restart2", SAW1, SAW1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
